// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory behind a valid/ready request port.
// Supports RV32 loads and stores, alignment/size error detection and programmable wait states.
module data_mem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // state  | meaning
  // S_IDLE | ready; captures a request on valid
  // S_WAIT | burning WAIT_STATES cycles via cnt_q
  // S_RESP | commit/sample edge leaving this state
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q;

  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       ld_data;
  logic              commit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          err_d   = (req_size_i == 2'b11) ||
                    (req_size_i == 2'b01 && req_addr_i[0]) ||
                    (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
          cnt_d   = 4'(WAIT_STATES - 1);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign a0     = addr_q;
  assign a1     = addr_q + ADDR_W'(1);
  assign a2     = addr_q + ADDR_W'(2);
  assign a3     = addr_q + ADDR_W'(3);
  assign commit = (state_q == S_RESP) && !err_q;

  always_comb begin
    b0 = mem_q[a0];
    b1 = mem_q[a1];
    b2 = mem_q[a2];
    b3 = mem_q[a3];
    ld_data = {b3, b2, b1, b0};
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   ld_data = uns_q ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: ld_data = {b3, b2, b1, b0};
    endcase
    rsp_rdata_d = (we_q || err_q) ? 32'h0 : ld_data;
  end

  // Array is deliberately outside the reset domain; an aborted store never reaches S_RESP.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem_q[a0] <= wdata_q[7:0];
      if (size_q != 2'b00) mem_q[a1] <= wdata_q[15:8];
      if (size_q == 2'b10) begin
        mem_q[a2] <= wdata_q[23:16];
        mem_q[a3] <= wdata_q[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_valid_q <= (state_q == S_RESP);
      rsp_rdata_q <= (state_q == S_RESP) ? rsp_rdata_d : 32'h0;
      rsp_err_q   <= (state_q == S_RESP) && err_q;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance 0 has no wait states, instance 1 has three.
// Directed plan scenarios plus randomized accesses against a byte-array reference model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [11:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [2][4096];
  int wait_of [2] = '{0, 3};

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_size_i(req_size[0]), .req_unsigned_i(req_unsigned[0]), .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]));

  data_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_size_i(req_size[1]), .req_unsigned_i(req_unsigned[1]), .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]));

  // Reference: an access touches 2**size bytes, little-endian, must be naturally aligned.
  function automatic void model_access(input int d, input bit we, input logic [1:0] size,
                                       input bit uns, input int addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int n;
    longint v;
    n = (size == 2'b11) ? 0 : (1 << size);
    err = (n == 0) ? 1'b1 : ((addr % n) != 0);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mdl[d][addr + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mdl[d][addr + i]) << (8 * i));
      if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      rdata = v[31:0];
    end
  endfunction

  task automatic set_req(input int d, input bit we, input logic [1:0] size, input bit uns,
                         input logic [11:0] addr, input logic [31:0] wdata);
    req_we[d] = we; req_size[d] = size; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wdata;
  endtask

  // Drives one request; lat is the number of edges after acceptance until rsp_valid is seen.
  task automatic access(input int d, input bit we, input logic [1:0] size, input bit uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rdy_hi);
    int guard;
    set_req(d, we, size, uns, addr, wdata);
    req_valid[d] = 1'b1;
    guard = 0;
    while (req_ready[d] !== 1'b1 && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = -1; rdy_hi = 0; rdata = 'x; err = 1'bx;
    if (req_ready[d] === 1'b1) rdy_hi++;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (rsp_valid[d] === 1'b1) begin
        lat = j; rdata = rsp_rdata[d]; err = rsp_err[d];
        break;
      end
      if (req_ready[d] === 1'b1) rdy_hi++;
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 ||
          rsp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
  endtask

  task automatic test_word_roundtrip;
    logic [31:0] rd, er; logic e, ee; int lat, rh;
    model_access(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, er, ee);
    access(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, rd, e, lat, rh);
    checks++;
    if (lat !== 1 || e !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_word: lat=%0d err=%b rdata=%h, want 1 0 0", lat, e, rd);
    end
    model_access(0, 0, 2'b10, 0, 12'h010, 32'h0, er, ee);
    access(0, 0, 2'b10, 0, 12'h010, 32'h0, rd, e, lat, rh);
    checks++;
    if (lat !== 1 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_word: lat=%0d err=%b rdata=%h, want 1 0 deadbeef", lat, e, rd);
    end
  endtask

  task automatic test_extension;
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    bit          un [4] = '{0, 1, 0, 1};
    logic [11:0] ad [4] = '{12'h011, 12'h011, 12'h012, 12'h012};
    logic [31:0] ex [4] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD};
    logic [31:0] rd, er; logic e, ee; int lat, rh;
    for (int i = 0; i < 4; i++) begin
      model_access(0, 0, sz[i], un[i], int'(ad[i]), 32'h0, er, ee);
      access(0, 0, sz[i], un[i], ad[i], 32'h0, rd, e, lat, rh);
      checks++;
      if (rd !== ex[i] || e !== 1'b0 || lat !== 1) begin
        errors++;
        $display("FAIL load_ext[%0d]: rdata=%h err=%b lat=%0d, want %h 0 1", i, rd, e, lat, ex[i]);
      end
    end
  endtask

  task automatic test_partial_store;
    logic [31:0] rd, er; logic e, ee; int lat, rh;
    model_access(0, 1, 2'b00, 0, 12'h013, 32'h00000055, er, ee);
    access(0, 1, 2'b00, 0, 12'h013, 32'hCCCCCC55, rd, e, lat, rh);
    model_access(0, 0, 2'b10, 0, 12'h010, 32'h0, er, ee);
    access(0, 0, 2'b10, 0, 12'h010, 32'h0, rd, e, lat, rh);
    checks++;
    if (rd !== 32'h55ADBEEF) begin
      errors++;
      $display("FAIL sb_then_lw: rdata=%h, want 55adbeef", rd);
    end
    model_access(0, 1, 2'b01, 0, 12'h010, 32'h00001234, er, ee);
    access(0, 1, 2'b01, 0, 12'h010, 32'hAAAA1234, rd, e, lat, rh);
    model_access(0, 0, 2'b10, 0, 12'h010, 32'h0, er, ee);
    access(0, 0, 2'b10, 0, 12'h010, 32'h0, rd, e, lat, rh);
    checks++;
    if (rd !== 32'h55AD1234) begin
      errors++;
      $display("FAIL sh_then_lw: rdata=%h, want 55ad1234", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, er; logic e, ee; int lat, rh;
    access(0, 1, 2'b10, 0, 12'h021, 32'hFFFFFFFF, rd, e, lat, rh);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      errors++;
      $display("FAIL sw_misaligned: err=%b rdata=%h lat=%0d, want 1 0 1", e, rd, lat);
    end
    model_access(0, 0, 2'b10, 0, 12'h020, 32'h0, er, ee);
    access(0, 0, 2'b10, 0, 12'h020, 32'h0, rd, e, lat, rh);
    checks++;
    if (e !== 1'b0 || rd !== er) begin
      errors++;
      $display("FAIL lw_after_bad_sw: err=%b rdata=%h, want 0 %h", e, rd, er);
    end
    access(0, 0, 2'b01, 0, 12'h003, 32'h0, rd, e, lat, rh);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL lh_misaligned: err=%b rdata=%h, want 1 0", e, rd);
    end
    access(0, 0, 2'b11, 0, 12'h010, 32'h0, rd, e, lat, rh);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL size_illegal: err=%b rdata=%h, want 1 0", e, rd);
    end
  endtask

  // Request B is held valid while A is in flight; it must be taken on A's response cycle.
  task automatic test_wait_states;
    logic [31:0] er; logic ee; bit ev, eready;
    model_access(1, 1, 2'b10, 0, 12'h080, 32'h0BADF00D, er, ee);
    model_access(1, 0, 2'b10, 0, 12'h080, 32'h0, er, ee);
    set_req(1, 1, 2'b10, 0, 12'h080, 32'h0BADF00D);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    set_req(1, 0, 2'b10, 0, 12'h080, 32'h0);
    checks++;
    if (req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL ws_ready_j0: ready=%b, want 0", req_ready[1]);
    end
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk); #1;
      if (j == 5) req_valid[1] = 1'b0;
      ev = (j == 4) || (j == 9);
      eready = ev;
      checks++;
      if (rsp_valid[1] !== ev || req_ready[1] !== eready) begin
        errors++;
        $display("FAIL ws_timing j=%0d: valid=%b ready=%b, want %b %b",
                 j, rsp_valid[1], req_ready[1], ev, eready);
      end
      if (j == 9) begin
        checks++;
        if (rsp_rdata[1] !== er || rsp_err[1] !== 1'b0) begin
          errors++;
          $display("FAIL ws_b2b_load: rdata=%h err=%b, want %h 0", rsp_rdata[1], rsp_err[1], er);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic e; int lat, rh; int seen;
    set_req(1, 1, 2'b10, 0, 12'h040, 32'hA5A5A5A5);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 ||
        rsp_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
    end
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (rsp_valid[1] === 1'b1) seen++; end
    rst_n[1] = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (rsp_valid[1] === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_rsp: rsp_valid seen %0d times, want 0", seen);
    end
    access(1, 0, 2'b10, 0, 12'h040, 32'h0, rd, e, lat, rh);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL reset_mid_lw: rdata=%h err=%b lat=%0d, want 0 0 4", rd, e, lat);
    end
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] rd, er, wd; logic e, ee; int lat, rh, addr;
    bit we, uns; logic [1:0] sz;
    for (int i = 0; i < n; i++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = 256 + int'($urandom_range(0, 63));
      wd   = $urandom;
      model_access(d, we, sz, uns, addr, wd, er, ee);
      access(d, we, sz, uns, 12'(addr), wd, rd, e, lat, rh);
      checks++;
      if (rd !== er || e !== ee || lat !== wait_of[d] + 1 || rh !== 0) begin
        errors++;
        $display("FAIL random dut%0d #%0d we=%b sz=%0d a=%h: rdata=%h err=%b lat=%0d rdyhi=%0d, want %h %b %0d 0",
                 d, i, we, sz, addr, rd, e, lat, rh, er, ee, wait_of[d] + 1);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 4096; a++) mdl[d][a] = 8'h00;
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      set_req(d, 0, 2'b00, 0, 12'h000, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;
    test_word_roundtrip();
    test_extension();
    test_partial_store();
    test_errors();
    test_wait_states();
    test_reset_mid();
    test_random(0, 80);
    test_random(1, 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, byte-addressable, little-endian data memory with a valid/ready request port and a one-cycle response pulse.
- Supports RV32 byte, half-word and word loads and stores, with signed or unsigned load extension.
- Detects misaligned and illegal-size accesses.
- Inserts a programmable number of wait states, so the load/store unit can be exercised against slow memory.
- Sits between the LSU and the data address space.

Parameters:
ADDR_W, 12, byte-address width; capacity is 2**ADDR_W bytes.
WAIT_STATES, 0, extra cycles spent in WAIT before the response; legal range 0..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half-word, 10 word, 11 illegal.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data; the low bits are used for byte and half stores.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  misaligned or illegal access, qualified by rsp_valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The memory array is not reset; it is zero-initialised at time 0 only.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, capture we, size, unsigned, addr and wdata, and compute err. Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: req_ready=0. A 4-bit counter loaded with WAIT_STATES-1 counts down. At 0, go to RESP.
  - RESP: req_ready=0. Go to IDLE on the next edge.
- Response timing: the registered outputs rsp_valid, rsp_rdata and rsp_err are driven high/valid for exactly the one cycle after the edge on which RESP is left. Acceptance at edge T0 gives rsp_valid high in cycle T0+WAIT_STATES+2. req_ready returns to 1 in that same cycle.
- Back-to-back throughput: one access per WAIT_STATES+2 cycles. A request presented while rsp_valid=1 may be accepted in that cycle.
- Commit point: stores write the array on the edge that leaves RESP. Loads sample the array on the same edge.
- Error conditions:
  - err=1 if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
  - On err: no array write, rsp_rdata=0, rsp_err=1.
- Stores (little-endian): byte writes mem[a]. Half writes mem[a], mem[a+1]. Word writes mem[a..a+3]. Bytes outside the access are untouched.
- Loads (little-endian):
  - Byte result is mem[a], extended from bit 7. Half result is {mem[a+1],mem[a]}, extended from bit 15. Word result is mem[a+3..a].
  - Extension is signed unless req_unsigned=1.
- Address range: aligned accesses never wrap, because alignment is enforced and the capacity is a multiple of 4.
- Inputs outside IDLE: req_* inputs are ignored while req_ready=0. The requester must hold its request until accepted.
- Reset mid-operation: the FSM aborts to IDLE and the captured request is discarded. A store not yet committed is not performed, and no response is produced.
- Load of a location written by the immediately preceding store returns the new data, because that store committed before the load's commit edge.

Test Plan:
- Word round trip, WAIT_STATES=0: sw 0xDEADBEEF @0x010, then lw @0x010 → rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 2 cycles after each acceptance.
- Byte and half extension, after the word store above: lb @0x011 → 0xFFFFFFBE; lbu @0x011 → 0x000000BE; lh @0x012 → 0xFFFFDEAD; lhu @0x012 → 0x0000DEAD.
- Partial store: sb 0x55 @0x013, then lw @0x010 → 0x55ADBEEF; sh 0x1234 @0x010, then lw → 0x55AD1234.
- Misaligned and illegal accesses:
  - sw 0xFFFFFFFF @0x021 → rsp_err=1, rsp_rdata=0; lw @0x020 still reads its previous value.
  - lh @0x003 → rsp_err=1.
  - size=11 → rsp_err=1.
- Wait states, WAIT_STATES=3: accept at edge T0 → rsp_valid high only in cycle T0+5; req_ready=0 for cycles T0+1..T0+4; a second request held high meanwhile is accepted exactly in cycle T0+5.
- Reset mid-store, WAIT_STATES=3: sw 0xA5A5A5A5 @0x040, assert rst_n=0 in cycle T0+2 → outputs reset immediately, no rsp_valid ever appears; after release, lw @0x040 returns the prior contents (0).
